// File: rtl/mux_4to1_pkg.sv
// Shared constants for the registered 4-to-1 multiplexer.
// Holds the select encodings ({sel1, sel0}) and the default data width.
// Imported by the RTL and by the testbench so both agree on encodings.
package mux_4to1_pkg;

    // Default bit width of each data input and of the output.
    localparam int DEFAULT_WIDTH = 1;

    // Select encodings, index = {sel1, sel0}.
    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b01;
    localparam logic [1:0] SEL_I2 = 2'b10;
    localparam logic [1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_4to1_mux_2_1.sv
// Purpose: combinational 2-to-1 selector, one node of the 4-to-1 tree.
// Latency: none (pure combinational path from sel/a/b to y).
// Backpressure: none; output follows inputs continuously.
module mux_2_1 #(
    parameter int WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // a is chosen when sel is 0, b when sel is 1.
    assign y = sel ? b : a;

endmodule

// File: rtl/mux_4to1.sv
// Purpose: registered 4-to-1 mux choosing i0..i3 by {sel1, sel0}.
// Latency: one clk cycle from sampled inputs to y/out_valid.
// Backpressure: none; accepts one result per valid cycle, holds y when idle.
module mux_4to1
    import mux_4to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel0,
    input  logic             sel1,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_stage_a;
    logic [WIDTH-1:0] w_stage_b;
    logic [WIDTH-1:0] w_result;

    logic [WIDTH-1:0] r_y;
    logic             r_out_valid;

    // First level: sel0 picks within the low pair (i0/i1).
    mux_2_1 #(.WIDTH(WIDTH)) u_stage_a (
        .sel (sel0),
        .a   (i0),
        .b   (i1),
        .y   (w_stage_a)
    );

    // First level: sel0 picks within the high pair (i2/i3).
    mux_2_1 #(.WIDTH(WIDTH)) u_stage_b (
        .sel (sel0),
        .a   (i2),
        .b   (i3),
        .y   (w_stage_b)
    );

    // Final level: sel1 picks between the two pairs.
    mux_2_1 #(.WIDTH(WIDTH)) u_stage_final (
        .sel (sel1),
        .a   (w_stage_a),
        .b   (w_stage_b),
        .y   (w_result)
    );

    // Capture the tree output on valid cycles; valid flag tracks in_valid; reset clears both at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_result;
            end
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1 with WIDTH=1 and WIDTH=8 instances.
// Directed steps from the test plan followed by randomized traffic.
// Expected values come from an array-indexed reference model.
module tb_mux_4to1;
    import mux_4to1_pkg::*;

    logic clk;
    logic rst;

    // WIDTH=1 instance signals
    logic       sel0_1, sel1_1, in_valid_1;
    logic [0:0] i0_1, i1_1, i2_1, i3_1;
    logic [0:0] y_1;
    logic       out_valid_1;

    // WIDTH=8 instance signals
    logic       sel0_8, sel1_8, in_valid_8;
    logic [7:0] i0_8, i1_8, i2_8, i3_8;
    logic [7:0] y_8;
    logic       out_valid_8;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] exp_y8;
    logic       exp_v8;
    logic [0:0] exp_y1;
    logic       exp_v1;

    mux_4to1 #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .sel0      (sel0_1),
        .sel1      (sel1_1),
        .i0        (i0_1),
        .i1        (i1_1),
        .i2        (i2_1),
        .i3        (i3_1),
        .in_valid  (in_valid_1),
        .y         (y_1),
        .out_valid (out_valid_1)
    );

    mux_4to1 #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .sel0      (sel0_8),
        .sel1      (sel1_8),
        .i0        (i0_8),
        .i1        (i1_8),
        .i2        (i2_8),
        .i3        (i3_8),
        .in_valid  (in_valid_8),
        .y         (y_8),
        .out_valid (out_valid_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle on the WIDTH=8 instance, update the model, check after the edge.
    task automatic step8(input string tag, input logic [1:0] s,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3,
                         input logic v);
        logic [7:0] src [4];
        @(negedge clk);
        {sel1_8, sel0_8} = s;
        i0_8 = d0; i1_8 = d1; i2_8 = d2; i3_8 = d3;
        in_valid_8 = v;
        src = '{d0, d1, d2, d3};
        if (v) exp_y8 = src[s];
        exp_v8 = v;
        @(posedge clk);
        #1;
        chk({tag, ".y"}, y_8, exp_y8);
        chk({tag, ".vld"}, {7'd0, out_valid_8}, {7'd0, exp_v8});
    endtask

    // Drive one cycle on the WIDTH=1 instance, update the model, check after the edge.
    task automatic step1(input string tag, input logic [1:0] s,
                         input logic [3:0] d, input logic v);
        @(negedge clk);
        {sel1_1, sel0_1} = s;
        {i3_1, i2_1, i1_1, i0_1} = d;
        in_valid_1 = v;
        if (v) exp_y1 = d[s];
        exp_v1 = v;
        @(posedge clk);
        #1;
        chk({tag, ".y"}, {7'd0, y_1}, {7'd0, exp_y1});
        chk({tag, ".vld"}, {7'd0, out_valid_1}, {7'd0, exp_v1});
    endtask

    // Pulse reset between edges on the WIDTH=8 instance and check outputs clear before the next edge.
    task automatic reset_pulse8(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_y8 = '0;
        exp_v8 = 1'b0;
        chk({tag, ".y"}, y_8, exp_y8);
        chk({tag, ".vld"}, {7'd0, out_valid_8}, {7'd0, exp_v8});
        @(negedge clk);
        rst = 1'b0;
        in_valid_8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sel0_1 = 0; sel1_1 = 0; in_valid_1 = 1'b1;
        i0_1 = 0; i1_1 = 0; i2_1 = 0; i3_1 = 0;
        sel0_8 = 0; sel1_8 = 0; in_valid_8 = 1'b1;
        i0_8 = 8'h11; i1_8 = 8'h22; i2_8 = 8'h33; i3_8 = 8'h44;
        exp_y8 = '0; exp_v8 = 1'b0;
        exp_y1 = '0; exp_v1 = 1'b0;

        // Reset state, with in_valid high across edges while in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.y8", y_8, 8'h00);
        chk("rst.vld8", {7'd0, out_valid_8}, 8'h00);
        chk("rst.y1", {7'd0, y_1}, 8'h00);
        chk("rst.vld1", {7'd0, out_valid_1}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        in_valid_1 = 1'b0;
        in_valid_8 = 1'b0;

        // Exhaustive select, WIDTH=1, {i3,i2,i1,i0}=4'h5.
        step1("w1.s00", SEL_I0, 4'h5, 1'b1);
        chk("w1.s00.const", {7'd0, y_1}, 8'h01);
        step1("w1.s10", SEL_I2, 4'h5, 1'b1);
        chk("w1.s10.const", {7'd0, y_1}, 8'h01);
        step1("w1.s01", SEL_I1, 4'h5, 1'b1);
        chk("w1.s01.const", {7'd0, y_1}, 8'h00);
        step1("w1.s11", SEL_I3, 4'h5, 1'b1);
        chk("w1.s11.const", {7'd0, y_1}, 8'h00);

        // Randomized WIDTH=1 traffic.
        for (int k = 0; k < 60; k++) begin
            step1("w1.rnd", 2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        @(negedge clk);
        in_valid_1 = 1'b0;

        // Wide data, back-to-back selects.
        step8("w8.s00", SEL_I0, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1);
        chk("w8.s00.const", y_8, 8'hA5);
        step8("w8.s01", SEL_I1, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1);
        chk("w8.s01.const", y_8, 8'h3C);
        step8("w8.s10", SEL_I2, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1);
        chk("w8.s10.const", y_8, 8'hFF);
        step8("w8.s11", SEL_I3, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1);
        chk("w8.s11.const", y_8, 8'h00);

        // Hold: capture 3C, then idle with changed sel and data.
        step8("hold.cap", SEL_I1, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1);
        step8("hold.idle1", SEL_I3, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        step8("hold.idle2", SEL_I0, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0);
        chk("hold.const.y", y_8, 8'h3C);
        chk("hold.const.vld", {7'd0, out_valid_8}, 8'h00);

        // Asynchronous reset while y=FF, then first valid capture after release.
        step8("arst.pre", SEL_I2, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1);
        chk("arst.pre.const", y_8, 8'hFF);
        @(negedge clk);
        in_valid_8 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.y_now", y_8, 8'h00);
        chk("arst.vld_now", {7'd0, out_valid_8}, 8'h00);
        exp_y8 = '0;
        exp_v8 = 1'b0;
        @(posedge clk);
        #1;
        chk("arst.y_held", y_8, 8'h00);
        chk("arst.vld_held", {7'd0, out_valid_8}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        in_valid_8 = 1'b0;
        step8("arst.first", SEL_I3, 8'h01, 8'h02, 8'h03, 8'h5A, 1'b1);
        chk("arst.first.const", y_8, 8'h5A);

        // Mid-cycle glitch on sel0 with sel1=0; only the settled value is captured.
        @(negedge clk);
        sel1_8 = 1'b0;
        i0_8 = 8'hC3; i1_8 = 8'h96; i2_8 = 8'h0F; i3_8 = 8'hF0;
        in_valid_8 = 1'b1;
        for (int g = 0; g < 3; g++) begin
            sel0_8 = ~sel0_8;
            #1;
            chk("glitch.between", y_8, 8'h5A);
        end
        sel0_8 = 1'b1;
        @(posedge clk);
        #1;
        exp_y8 = 8'h96;
        exp_v8 = 1'b1;
        chk("glitch.y", y_8, exp_y8);
        chk("glitch.vld", {7'd0, out_valid_8}, {7'd0, exp_v8});

        // Randomized WIDTH=8 traffic with occasional mid-stream resets.
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset_pulse8("rnd.rst");
            end
            step8("w8.rnd", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
